// File: rtl/pdm_capture_controller_if.sv
// Handshake and pin bundle between the PDM capture controller and its surroundings.
// The slave modport is the controller side; the master modport is the mic/consumer side.
interface pdm_capture_controller_if #(
  parameter int unsigned WORD_LENGTH = 16
);
  logic                   start;
  logic                   stop;
  logic                   micData;
  logic                   micClock;
  logic                   LRSEL;
  logic [WORD_LENGTH-1:0] sampleOut;
  logic                   sampleValid;
  logic                   sampleReady;
  logic                   overrun;
  logic                   busy;

  modport master (
    output start, stop, micData, sampleReady,
    input  micClock, LRSEL, sampleOut, sampleValid, overrun, busy
  );

  modport slave (
    input  start, stop, micData, sampleReady,
    output micClock, LRSEL, sampleOut, sampleValid, overrun, busy
  );
endinterface

// File: rtl/pdm_capture_controller.sv
// PDM microphone capture sequencer: bit-clock generation, warm-up discard, word packing
// and a one-entry valid/ready holding register with sticky overrun.
module pdm_capture_controller #(
  parameter int unsigned WORD_LENGTH        = 16,
  parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
  parameter int unsigned SAMPLING_FREQUENCY = 1000000,
  parameter int unsigned WARMUP_BITS        = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  pdm_capture_controller_if.slave  bus
);

  localparam int unsigned HALF      = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
  localparam int unsigned DIV_W     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W     = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam int unsigned WARM_W    = (WARMUP_BITS > 1) ? $clog2(WARMUP_BITS) : 1;
  localparam int unsigned WARM_LAST = (WARMUP_BITS > 0) ? WARMUP_BITS - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DIV_W-1:0]       r_div;
  logic                   r_mic_clk;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [WARM_W-1:0]      r_warm_cnt;
  logic [WORD_LENGTH-1:0] r_shift;
  logic [WORD_LENGTH-1:0] r_sample;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_busy;

  logic                   w_div_end;
  logic                   w_cap_event;
  logic                   w_word_done;
  logic                   w_start_ok;
  logic [WORD_LENGTH-1:0] w_word;

  // The completing bit is always the top one, so the finished word is the shift
  // register with the live micData spliced in.
  assign w_word = {bus.micData, r_shift[WORD_LENGTH-2:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_end   = (r_div == DIV_W'(HALF - 1));
    w_cap_event = (r_state != ST_IDLE) && r_mic_clk && w_div_end;
    w_word_done = (r_state == ST_CAPTURE) && w_cap_event &&
                  (r_bit_cnt == BIT_W'(WORD_LENGTH - 1));
    w_start_ok  = (r_state == ST_IDLE) && bus.start && !bus.stop;

    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (WARMUP_BITS == 0) ? ST_CAPTURE : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cap_event && (r_warm_cnt == WARM_W'(WARM_LAST))) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_mic_clk  <= 1'b0;
      r_bit_cnt  <= '0;
      r_warm_cnt <= '0;
      r_shift    <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Bit clock only runs inside a session; leaving one forces it low at once.
      if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE)) begin
        r_div     <= '0;
        r_mic_clk <= 1'b0;
      end else if (w_div_end) begin
        r_div     <= '0;
        r_mic_clk <= ~r_mic_clk;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      if ((r_state == ST_WARMUP) && w_cap_event) begin
        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      end
      if (w_state_nxt != ST_WARMUP) begin
        r_warm_cnt <= '0;
      end

      if ((r_state == ST_CAPTURE) && w_cap_event) begin
        r_shift[r_bit_cnt] <= bus.micData;
        r_bit_cnt          <= w_word_done ? '0 : r_bit_cnt + BIT_W'(1);
      end
      if (w_state_nxt == ST_IDLE) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end

      // Holding register: a finished word may replace one being consumed this edge.
      if (w_word_done) begin
        if (!r_valid || bus.sampleReady) begin
          r_sample <= w_word;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.sampleReady) begin
        r_valid <= 1'b0;
      end

      if (w_start_ok) begin
        r_overrun <= 1'b0;
      end

      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.micClock    = r_mic_clk;
  assign bus.LRSEL       = 1'b0;
  assign bus.sampleOut   = r_sample;
  assign bus.sampleValid = r_valid;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_pdm_capture_controller.sv
// Randomized bench for pdm_capture_controller against an edge-counting behavioural model.
module tb_pdm_capture_controller;

  localparam int unsigned WL   = 16;
  localparam int unsigned HALF = 50;
  localparam int unsigned WARM = 4;
  localparam int unsigned PER  = 2 * HALF;

  logic clock;
  logic reset;

  pdm_capture_controller_if #(.WORD_LENGTH(WL)) bus();

  pdm_capture_controller #(
    .WORD_LENGTH(WL),
    .SYSTEM_FREQUENCY(100000000),
    .SAMPLING_FREQUENCY(1000000),
    .WARMUP_BITS(WARM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model: session time counted in edges since the start edge.
  bit          m_active;
  int          m_t;
  int          m_k;
  logic [WL-1:0] m_acc;
  logic [WL-1:0] m_word;
  bit          m_valid;
  bit          m_overrun;
  bit          m_mic;

  bit pattern_on;
  bit rand_ready;
  logic [WL-1:0] snap;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", tag, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_active  = 0;
    m_t       = 0;
    m_k       = 0;
    m_acc     = '0;
    m_word    = '0;
    m_valid   = 0;
    m_overrun = 0;
    m_mic     = 0;
  endfunction

  function automatic void model_edge();
    bit done;
    int pos;
    done = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      if (bus.start && !bus.stop) begin
        m_active  = 1;
        m_t       = 0;
        m_k       = 0;
        m_overrun = 0;
        m_mic     = 0;
      end
    end else begin
      m_t++;
      if (m_t % PER == 0) begin
        m_k++;
        if (m_k > WARM) begin
          pos        = (m_k - WARM - 1) % WL;
          m_acc[pos] = bus.micData;
          done       = (pos == WL - 1);
        end
      end
      if (bus.stop) begin
        m_active = 0;
        m_mic    = 0;
      end else begin
        m_mic = ((m_t / HALF) % 2) == 1;
      end
    end
    if (done) begin
      if (!m_valid || bus.sampleReady) begin
        m_word  = m_acc;
        m_valid = 1;
      end else begin
        m_overrun = 1;
      end
    end else if (m_valid && bus.sampleReady) begin
      m_valid = 0;
    end
  endfunction

  function automatic logic [31:0] dut_vec();
    return {11'b0, bus.micClock, bus.LRSEL, bus.busy, bus.sampleValid, bus.overrun, bus.sampleOut};
  endfunction

  function automatic logic [31:0] model_vec();
    return {11'b0, m_mic, 1'b0, m_active, m_valid, m_overrun, m_word};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_value("outputs", dut_vec(), model_vec());
  endtask

  task automatic drive_inputs();
    int nxt;
    nxt = m_active ? m_t + 1 : 0;
    if (pattern_on && nxt > 0 && (nxt % PER) == 0 && (nxt / PER) >= 5 && (nxt / PER) <= 20)
      bus.micData = ((nxt / PER) % 2) == 1;
    else
      bus.micData = 1'($urandom_range(0, 1));
    if (rand_ready)
      bus.sampleReady = ($urandom_range(0, 99) < 2);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      step();
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    run(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    run(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.micData     = 1'b0;
    bus.sampleReady = 1'b0;
    pattern_on      = 0;
    rand_ready      = 0;
    model_reset();

    // Reset and idle
    run(3);
    reset = 1'b0;
    run(500);
    check_value("idle_outs", dut_vec(), 32'h0);

    // Alternating pattern word, consumer always ready
    pattern_on      = 1;
    bus.sampleReady = 1'b1;
    pulse_start();
    check_value("busy_rise", 32'(bus.busy), 32'd1);
    run(49);
    check_value("mclk_t49", 32'(bus.micClock), 32'd0);
    run(1);
    check_value("mclk_t50", 32'(bus.micClock), 32'd1);
    run(49);
    check_value("mclk_t99", 32'(bus.micClock), 32'd1);
    run(1);
    check_value("mclk_t100", 32'(bus.micClock), 32'd0);
    run(50);
    check_value("mclk_t150", 32'(bus.micClock), 32'd1);
    run(1849);
    check_value("valid_t1999", 32'(bus.sampleValid), 32'd0);
    run(1);
    check_value("valid_t2000", 32'(bus.sampleValid), 32'd1);
    check_value("word_5555", 32'(bus.sampleOut), 32'h5555);
    run(1);
    check_value("valid_pulse_end", 32'(bus.sampleValid), 32'd0);
    pulse_stop();
    pattern_on = 0;
    run(5);

    // Consumer stalled for two words -> overrun
    bus.sampleReady = 1'b0;
    pulse_start();
    run(2000);
    check_value("stall_valid_t2000", 32'(bus.sampleValid), 32'd1);
    snap = m_word;
    run(1599);
    check_value("ovr_t3599", 32'(bus.overrun), 32'd0);
    run(1);
    check_value("ovr_t3600", 32'(bus.overrun), 32'd1);
    check_value("word1_held", 32'(bus.sampleOut), 32'(snap));
    pulse_stop();
    run(10);
    check_value("ovr_sticky", 32'(bus.overrun), 32'd1);
    pulse_start();
    check_value("ovr_cleared", 32'(bus.overrun), 32'd0);
    run(20);
    pulse_stop();
    bus.sampleReady = 1'b1;
    run(2);
    bus.sampleReady = 1'b0;
    check_value("drained", 32'(bus.sampleValid), 32'd0);

    // Ready only on word 2's completion edge
    pulse_start();
    run(2000);
    run(1599);
    bus.sampleReady = 1'b1;
    step();
    bus.sampleReady = 1'b0;
    check_value("w2_valid", 32'(bus.sampleValid), 32'd1);
    check_value("w2_no_ovr", 32'(bus.overrun), 32'd0);
    check_value("w2_word", 32'(bus.sampleOut), 32'(m_acc));
    pulse_stop();
    bus.sampleReady = 1'b1;
    run(2);

    // Stop mid-word then restart
    pulse_start();
    run(1249);
    pulse_stop();
    check_value("stop_busy", 32'(bus.busy), 32'd0);
    check_value("stop_mclk", 32'(bus.micClock), 32'd0);
    run(1000);
    check_value("stop_no_word", 32'(bus.sampleValid), 32'd0);
    bus.sampleReady = 1'b0;
    pulse_start();
    run(1999);
    check_value("restart_t1999", 32'(bus.sampleValid), 32'd0);
    run(1);
    check_value("restart_t2000", 32'(bus.sampleValid), 32'd1);
    pulse_stop();
    bus.sampleReady = 1'b1;
    run(3);

    // Asynchronous reset just before the first word completes
    pulse_start();
    run(1998);
    reset = 1'b1;
    #1;
    check_value("async_reset", dut_vec(), 32'h0);
    model_reset();
    run(3);
    reset = 1'b0;
    run(200);
    check_value("no_word_after_rst", 32'(bus.sampleValid), 32'd0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    run(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_value("start_stop_idle", 32'(bus.busy), 32'd0);
    run(300);
    check_value("idle_mclk", 32'(bus.micClock), 32'd0);

    // Random sessions with a sporadic consumer
    rand_ready = 1;
    for (int s = 0; s < 3; s++) begin
      pulse_start();
      run(int'($urandom_range(2500, 6000)));
      pulse_stop();
      run(int'($urandom_range(5, 50)));
    end
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pdm_capture_controller.md
# pdm_capture_controller

Sequencer for the 16-bit microphone deserializer path: generates the PDM microphone bit clock from the system clock, ties the left/right select, discards mic start-up bits, packs captured bits into 16-bit words and hands each word to the downstream sample consumer through a one-entry valid/ready holding register with sticky overrun detection. It sits between the board microphone pins and the audio sample consumer, replacing free-running deserializer enables with an explicit start/stop controlled capture session.

## Interface
- WORD_LENGTH, 16: bits per output word.
- SYSTEM_FREQUENCY, 100000000: clock frequency, Hz.
- SAMPLING_FREQUENCY, 1000000: mic bit-clock frequency, Hz; HALF = SYSTEM_FREQUENCY/(2*SAMPLING_FREQUENCY), integer, ≥2 (default 50).
- WARMUP_BITS, 4: capture events discarded after each start.

- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
- start  input  1  one-cycle request to begin a capture session (ignored unless IDLE).
- stop  input  1  one-cycle request to end the session.
- micData  input  1  PDM data from microphone.
- micClock  output  1  generated mic bit clock, registered.
- LRSEL  output  1  channel select; constant 0 (left, data valid while micClock high).
- sampleOut  output  WORD_LENGTH  held word; bit i = i-th captured bit of the word.
- sampleValid  output  1  sampleOut holds an unconsumed word.
- sampleReady  input  1  consumer accepts word when sampleValid && sampleReady.
- overrun  output  1  sticky: a completed word was dropped.
- busy  output  1  high in WARMUP or CAPTURE.

## Operation
- Reset values: micClock 0, LRSEL 0, sampleOut 0, sampleValid 0, overrun 0, busy 0, state IDLE, divider 0, bit counter 0, warm-up counter 0.
- States: IDLE -> WARMUP on start; WARMUP -> CAPTURE after WARMUP_BITS capture events; WARMUP or CAPTURE -> IDLE on stop. WARMUP_BITS = 0 goes directly IDLE -> CAPTURE.
- Divider (not IDLE): each edge, if divider == HALF-1 then divider <= 0 and micClock toggles, else divider increments. In IDLE divider and micClock held 0.
- Capture event: edge with micClock == 1 and divider == HALF-1 (the edge driving micClock low); micData registered at that edge.
- WARMUP: capture events increment warm-up counter only; data discarded.
- CAPTURE: each event writes micData into shift word bit [bitCount], bitCount increments; on bitCount == WORD_LENGTH-1 the word completes and bitCount wraps to 0.
- Word completion: if !sampleValid, or sampleValid && sampleReady in the same cycle, sampleOut <= completed word, sampleValid <= 1, no overrun. Otherwise word dropped, sampleOut unchanged, overrun <= 1.
- Handshake: sampleValid && sampleReady without completion -> sampleValid <= 0 next edge. sampleOut stable while sampleValid high.
- Stop: state <= IDLE on the edge stop is sampled; micClock forced 0, divider 0, partial word and bitCount discarded. A held valid word stays until consumed. Stop and a word completion on the same edge: completion is honoured, then IDLE.
- start in WARMUP/CAPTURE ignored; start and stop same cycle in IDLE: stop wins, stays IDLE.
- overrun cleared only by reset or an accepted start.

## Timing
- Edge 0 = edge sampling start. micClock rises at edge HALF, falls at edge 2*HALF; capture event k (k ≥ 1) at edge 2*HALF*k.
- First word completes at event WARMUP_BITS + WORD_LENGTH; sampleValid high from that edge (defaults: edge 2000).
- Subsequent words every WORD_LENGTH*2*HALF edges (1600 at defaults).
- busy rises at edge 0, falls at the edge stop is sampled.
- reset mid-session: outputs to reset values asynchronously; no word emitted; next start begins a fresh warm-up.

## Test plan
- Reset then idle 500 cycles -> micClock 0, LRSEL 0, sampleValid 0, busy 0, overrun 0.
- start, micData driven so capture events 5..20 present alternating 1,0 starting 1, sampleReady = 1 -> sampleValid pulses at edge 2000, sampleOut = 16'h5555; micClock period 100 cycles, 50% duty.
- sampleReady held 0 for 2 words -> first word stays on sampleOut, overrun = 1 at edge 3600; start after stop clears overrun.
- sampleReady asserted exactly on the completion edge of word 2 -> word 2 loaded, sampleValid stays 1, overrun 0.
- stop at edge 1250 (mid-word 1) -> busy 0, micClock 0 next cycle, no sampleValid; restart yields first word 2000 edges after new start.
- Assert reset at edge 1999 -> all outputs at reset values, no word emitted; start/stop same cycle in IDLE -> remains IDLE.
